// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state type and ID-width helper for the FIFO write arbiter
package fifo_arb_pkg;
  typedef enum logic {IDLE, BURST} arb_state_e;
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotate-priority encoder, first valid index above last_grant wins
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req_valid,
  input  logic [ID_W-1:0]  i_last_grant,
  output logic             o_found,
  output logic [ID_W-1:0]  o_next_id
);
  logic [ID_W-1:0] w_idx;
  // scan from the farthest offset to the nearest so the nearest valid index overrides
  always_comb begin
    o_found   = 1'b0;
    o_next_id = '0;
    w_idx     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_idx = ID_W'((int'(i_last_grant) + k) % N_REQ);
      if (i_req_valid[w_idx]) begin
        o_found   = 1'b1;
        o_next_id = w_idx;
      end
    end
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among producers
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            i_req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [N_REQ-1:0]            o_req_ready,
  input  logic                        i_fifo_full,
  output logic                        o_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]       o_fifo_data_in,
  output logic [id_w(N_REQ)-1:0]      o_grant_id,
  output logic                        o_busy
);
  localparam int ID_W  = id_w(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  arb_state_e       r_state, w_state_nxt;
  logic [ID_W-1:0]  r_grant_id, r_last_grant, w_grant_nxt, w_last_nxt, w_pick_id;
  logic [CNT_W-1:0] r_burst_cnt, w_cnt_nxt;
  logic             w_busy, w_found, w_last_beat;

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
    .i_req_valid (i_req_valid),
    .i_last_grant(r_last_grant),
    .o_found     (w_found),
    .o_next_id   (w_pick_id)
  );

  assign w_busy       = (r_state == BURST);
  assign o_busy       = w_busy;
  assign o_grant_id   = r_grant_id;
  assign o_fifo_wr_en = w_busy & i_req_valid[r_grant_id] & ~i_fifo_full;
  assign w_last_beat  = (r_burst_cnt == CNT_W'(MAX_BURST - 1));

  // steer the granted producer's ready and data; everything is zero outside a burst
  always_comb begin
    o_req_ready    = '0;
    o_fifo_data_in = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_busy && r_grant_id == ID_W'(i)) begin
        o_req_ready[i] = ~i_fifo_full;
        o_fifo_data_in = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // grant in IDLE regardless of full; in BURST count beats and leave on burst end or producer dry
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant_id;
    w_cnt_nxt   = r_burst_cnt;
    w_last_nxt  = r_last_grant;
    if (r_state == IDLE) begin
      if (w_found) begin
        w_state_nxt = BURST;
        w_grant_nxt = w_pick_id;
        w_cnt_nxt   = '0;
      end
    end else begin
      if (o_fifo_wr_en) w_cnt_nxt = r_burst_cnt + 1'b1;
      if ((o_fifo_wr_en && w_last_beat) || (!i_fifo_full && !i_req_valid[r_grant_id])) begin
        w_state_nxt = IDLE;
        w_last_nxt  = r_grant_id;
      end
    end
  end

  // state and counters; reset points the round-robin so producer 0 goes first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_grant_id   <= '0;
      r_burst_cnt  <= '0;
      r_last_grant <= ID_W'(N_REQ - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_grant_id   <= w_grant_nxt;
      r_burst_cnt  <= w_cnt_nxt;
      r_last_grant <= w_last_nxt;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: vector table plus scoreboard of expected FIFO writes
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            fifo_full = 1'b0;
  logic            wr_en;
  logic [DW-1:0]   data_in;
  logic [1:0]      grant_id;
  logic            busy;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req_valid   (req_valid),
    .i_req_data    (req_data),
    .o_req_ready   (req_ready),
    .i_fifo_full   (fifo_full),
    .o_fifo_wr_en  (wr_en),
    .o_fifo_data_in(data_in),
    .o_grant_id    (grant_id),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    logic [3:0] v;
    logic       f;
    logic       wr;
    logic [3:0] rdy;
    logic       b;
    logic [1:0] g;
    logic [2:0] c;
  } vec_t;

  vec_t        vt[$];
  logic [17:0] sb[$];
  int          cnt[N];
  int          n_chk = 0;
  int          n_pass = 0;
  int          wr_seen = 0;
  int          grant_writes = 0;
  logic [N-1:0] acc;

  // writes made under the current grant, for the burst-length assertion
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) grant_writes <= 0;
    else if (!busy) grant_writes <= 0;
    else if (wr_en) grant_writes <= grant_writes + 1;
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
  a_no_wr_full:   assert property (@(posedge clk) disable iff (!rst_n) wr_en |-> !fifo_full);
  a_wr_valid:     assert property (@(posedge clk) disable iff (!rst_n) wr_en |-> req_valid[grant_id]);
  a_burst_len:    assert property (@(posedge clk) disable iff (!rst_n) wr_en |-> grant_writes < MB);

  function automatic logic [15:0] beat(int id, int k);
    return 16'(id * 'h1000 + 'hA0 + k);
  endfunction

  function automatic vec_t mk(bit rst, logic [3:0] v, logic f, logic wr, logic [3:0] rdy,
                              logic b, logic [1:0] g, logic [2:0] c);
    vec_t x;
    x.rst = rst; x.v = v; x.f = f; x.wr = wr; x.rdy = rdy; x.b = b; x.g = g; x.c = c;
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive_data();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = beat(i, cnt[i]);
  endtask

  task automatic push(int id, int first, int n);
    for (int k = first; k < first + n; k++) sb.push_back({2'(id), beat(id, k)});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    drive_data();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    if (wr_en) begin
      wr_seen++;
      if (sb.size() == 0) chk("sb_unexpected_write", {14'd0, grant_id, data_in}, 32'hFFFF_FFFF);
      else chk("sb_write", {14'd0, grant_id, data_in}, {14'd0, sb.pop_front()});
    end
    acc = req_valid & req_ready;
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) cnt[i]++;
    drive_data();
  endtask

  task automatic tick();
    at_neg();
    to_next();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // only producer 1 valid: one arbitration cycle, 4 beats, gap, regrant
    vt.push_back(mk(1, 4'b0010, 0, 0, 4'b0000, 0, 2'd0, 3'd0));
    vt.push_back(mk(0, 4'b0010, 0, 1, 4'b0010, 1, 2'd1, 3'd0));
    vt.push_back(mk(0, 4'b0010, 0, 1, 4'b0010, 1, 2'd1, 3'd1));
    vt.push_back(mk(0, 4'b0010, 0, 1, 4'b0010, 1, 2'd1, 3'd2));
    vt.push_back(mk(0, 4'b0010, 0, 1, 4'b0010, 1, 2'd1, 3'd3));
    vt.push_back(mk(0, 4'b0010, 0, 0, 4'b0000, 0, 2'd1, 3'd4));
    vt.push_back(mk(0, 4'b0010, 0, 1, 4'b0010, 1, 2'd1, 3'd0));
    push(1, 0, 5);
    // full stalls producer 0 for 3 cycles after 2 beats, then grant moves to 1
    vt.push_back(mk(1, 4'b0011, 0, 0, 4'b0000, 0, 2'd0, 3'd0));
    vt.push_back(mk(0, 4'b0011, 0, 1, 4'b0001, 1, 2'd0, 3'd0));
    vt.push_back(mk(0, 4'b0011, 0, 1, 4'b0001, 1, 2'd0, 3'd1));
    vt.push_back(mk(0, 4'b0011, 1, 0, 4'b0000, 1, 2'd0, 3'd2));
    vt.push_back(mk(0, 4'b0011, 1, 0, 4'b0000, 1, 2'd0, 3'd2));
    vt.push_back(mk(0, 4'b0011, 1, 0, 4'b0000, 1, 2'd0, 3'd2));
    vt.push_back(mk(0, 4'b0011, 0, 1, 4'b0001, 1, 2'd0, 3'd2));
    vt.push_back(mk(0, 4'b0011, 0, 1, 4'b0001, 1, 2'd0, 3'd3));
    vt.push_back(mk(0, 4'b0011, 0, 0, 4'b0000, 0, 2'd0, 3'd4));
    vt.push_back(mk(0, 4'b0011, 0, 1, 4'b0010, 1, 2'd1, 3'd0));
    push(0, 0, 4);
    push(1, 0, 1);
    // producer 2 runs dry after 2 beats while 3 and 0 wait: next grant is 3
    vt.push_back(mk(1, 4'b0100, 0, 0, 4'b0000, 0, 2'd0, 3'd0));
    vt.push_back(mk(0, 4'b1101, 0, 1, 4'b0100, 1, 2'd2, 3'd0));
    vt.push_back(mk(0, 4'b1101, 0, 1, 4'b0100, 1, 2'd2, 3'd1));
    vt.push_back(mk(0, 4'b1001, 0, 0, 4'b0100, 1, 2'd2, 3'd2));
    vt.push_back(mk(0, 4'b1001, 0, 0, 4'b0000, 0, 2'd2, 3'd2));
    vt.push_back(mk(0, 4'b1001, 0, 1, 4'b1000, 1, 2'd3, 3'd0));
    push(2, 0, 2);
    push(3, 0, 1);
    // grant taken while full; first write in the cycle full falls
    vt.push_back(mk(1, 4'b0010, 1, 0, 4'b0000, 0, 2'd0, 3'd0));
    vt.push_back(mk(0, 4'b0010, 1, 0, 4'b0000, 1, 2'd1, 3'd0));
    vt.push_back(mk(0, 4'b0010, 1, 0, 4'b0000, 1, 2'd1, 3'd0));
    vt.push_back(mk(0, 4'b0010, 0, 1, 4'b0010, 1, 2'd1, 3'd0));
    push(1, 0, 1);

    foreach (vt[j]) begin
      if (vt[j].rst) do_reset();
      req_valid = vt[j].v;
      fifo_full = vt[j].f;
      at_neg();
      chk($sformatf("v%0d_wr_en", j), {31'd0, wr_en}, {31'd0, vt[j].wr});
      chk($sformatf("v%0d_ready", j), {28'd0, req_ready}, {28'd0, vt[j].rdy});
      chk($sformatf("v%0d_busy", j), {31'd0, busy}, {31'd0, vt[j].b});
      chk($sformatf("v%0d_grant", j), {30'd0, grant_id}, {30'd0, vt[j].g});
      chk($sformatf("v%0d_burst_cnt", j), {29'd0, dut.r_burst_cnt}, {29'd0, vt[j].c});
      to_next();
    end
    chk("table_sb_drained", sb.size(), 0);

    // all four valid: order 0,1,2,3,0 with 20 writes in 25 cycles
    do_reset();
    req_valid = 4'b1111;
    push(0, 0, 4); push(1, 0, 4); push(2, 0, 4); push(3, 0, 4); push(0, 4, 4);
    wr_seen = 0;
    repeat (25) tick();
    req_valid = '0;
    chk("rr_write_count", wr_seen, 20);
    chk("rr_sb_drained", sb.size(), 0);

    // asynchronous reset mid-burst of producer 3, then producer 0 has priority again
    do_reset();
    req_valid = 4'b1000;
    push(3, 0, 2);
    repeat (3) tick();
    #1 chk("rst_wr_before", {31'd0, wr_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_data", {16'd0, data_in}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = 4'b1001;
    at_neg();
    chk("post_rst_idle", {31'd0, busy}, 32'd0);
    to_next();
    push(0, 0, 1);
    at_neg();
    chk("post_rst_grant", {30'd0, grant_id}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd1);
    chk("post_rst_wr", {31'd0, wr_en}, 32'd1);
    to_next();
    req_valid = '0;
    tick();
    chk("rst_sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
